// File: rtl/quire16_1_to_posit.sv
// quire16_1_to_posit: converts a 128-bit posit<16,1> quire beat into a posit16 (es=1) word.
// Three-stage pipeline (magnitude/flags -> LZC/normalise -> encode/round/sign) with rts/rtr
// handshake; the whole pipeline advances as one unit and stalls only when the output is held.
module quire16_1_to_posit #(
    parameter int unsigned QUIRE_W  = 128,
    parameter int unsigned POSIT_W  = 16,
    parameter int unsigned ES       = 1,
    parameter int unsigned FRAC_POS = 56
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rts_i,
    output logic               rtr_o,
    input  logic               sow_i,
    input  logic               eow_i,
    input  logic [QUIRE_W-1:0] data_i,
    input  logic               rtr_i,
    output logic               rts_o,
    output logic               sow_o,
    output logic               eow_o,
    output logic [POSIT_W-1:0] data_o
);
    localparam int unsigned MW = QUIRE_W - 1;      // magnitude width
    localparam int unsigned LW = $clog2(QUIRE_W);  // leading-zero count width
    localparam int unsigned BW = POSIT_W - 1;      // posit body width (no sign)
    localparam int unsigned FW = POSIT_W - 2;      // fraction bits kept after normalise
    localparam int unsigned XW = 32;               // encode scratch width, > longest body + guard
    localparam int unsigned SW = 8;                // signed scale width
    localparam logic [SW-1:0]        SCALE_TOP = SW'(MW - 1 - FRAC_POS);
    localparam logic signed [SW-1:0] SCALE_HI  = SW'((POSIT_W - 2) << ES);
    localparam logic signed [SW-1:0] SCALE_LO  = -SCALE_HI;

    // Stage registers
    logic          r_v1, r_v2, r_v3;
    logic          r_sow1, r_eow1, r_sow2, r_eow2;
    logic          r_nar1, r_zero1, r_s1, r_nar2, r_zero2, r_s2;
    logic [MW-1:0] r_mag1;
    logic signed [SW-1:0] r_scale2;
    logic [FW-1:0] r_frac2;
    logic          r_sticky2;
    logic          r_sow3, r_eow3;
    logic [POSIT_W-1:0] r_data3;

    logic w_adv;
    assign w_adv = ~(r_v3 & ~rtr_i);
    assign rtr_o = w_adv;

    // S1 combinational: special values and magnitude (low MW bits of the negation suffice)
    logic          w_nar, w_zero;
    logic [MW-1:0] w_mag;
    assign w_nar  = (data_i == {1'b1, {MW{1'b0}}});
    assign w_zero = (data_i == '0);
    assign w_mag  = data_i[MW] ? (~data_i[MW-1:0] + 1'b1) : data_i[MW-1:0];

    // S2 combinational: leading-zero count of the magnitude (highest set bit wins)
    logic [LW-1:0] w_lzc;
    always_comb begin
        w_lzc = LW'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (r_mag1[i]) w_lzc = LW'(int'(MW) - 1 - i);
        end
    end

    // Normalised magnitude with the hidden one shifted out of the top
    logic [MW-2:0]        w_norm;
    logic signed [SW-1:0] w_scale;
    assign w_norm  = (MW - 1)'(r_mag1 << w_lzc);
    assign w_scale = SCALE_TOP - SW'(w_lzc);

    // S3 combinational: regime/exponent/fraction packing, rounding, saturation and sign
    logic signed [SW-1:0] w_k;
    logic          w_kneg;
    logic [4:0]    w_kmag, w_rlen;
    logic [XW-1:0] w_rpat, w_body;
    logic [BW-1:0] w_trunc, w_rnd;
    logic          w_guard, w_st;
    logic [POSIT_W-1:0] w_abs, w_res;

    assign w_k     = r_scale2 >>> ES;
    assign w_kneg  = w_k[SW-1];
    assign w_kmag  = w_kneg ? 5'(-w_k) : 5'(w_k);
    assign w_rlen  = w_kneg ? w_kmag + 5'd1 : w_kmag + 5'd2;
    assign w_rpat  = w_kneg ? (32'h8000_0000 >> w_kmag) : ~(32'hFFFF_FFFF >> (w_kmag + 5'd1));
    assign w_body  = w_rpat | (XW'({r_scale2[0], r_frac2}) << (5'(XW - BW) - w_rlen));
    assign w_trunc = w_body[XW-1 -: BW];
    assign w_guard = w_body[XW-1-BW];
    assign w_st    = (|w_body[XW-2-BW:0]) | r_sticky2;
    // Cannot overflow: the longest in-range regime always ends in a zero bit
    assign w_rnd   = w_trunc + BW'(w_guard & (w_st | w_trunc[0]));

    // Select saturated / rounded magnitude, then apply sign and special overrides
    always_comb begin
        if (r_scale2 >= SCALE_HI) begin
            w_abs = {1'b0, {BW{1'b1}}};
        end else if (r_scale2 < SCALE_LO || w_rnd == '0) begin
            w_abs = POSIT_W'(1);
        end else begin
            w_abs = {1'b0, w_rnd};
        end
        w_res = r_s2 ? -w_abs : w_abs;
        if (r_zero2) w_res = '0;
        if (r_nar2)  w_res = {1'b1, {BW{1'b0}}};
    end

    // S1: capture accepted beat with flags and magnitude
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0; r_sow1 <= 1'b0; r_eow1 <= 1'b0;
            r_nar1 <= 1'b0; r_zero1 <= 1'b0; r_s1 <= 1'b0; r_mag1 <= '0;
        end else if (w_adv) begin
            r_v1 <= rts_i;
            if (rts_i) begin
                r_sow1 <= sow_i; r_eow1 <= eow_i;
                r_nar1 <= w_nar; r_zero1 <= w_zero; r_s1 <= data_i[MW]; r_mag1 <= w_mag;
            end
        end
    end

    // S2: scale, kept fraction and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0; r_sow2 <= 1'b0; r_eow2 <= 1'b0;
            r_nar2 <= 1'b0; r_zero2 <= 1'b0; r_s2 <= 1'b0;
            r_scale2 <= '0; r_frac2 <= '0; r_sticky2 <= 1'b0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sow2 <= r_sow1; r_eow2 <= r_eow1;
                r_nar2 <= r_nar1; r_zero2 <= r_zero1; r_s2 <= r_s1;
                r_scale2  <= w_scale;
                r_frac2   <= w_norm[MW-2 -: FW];
                r_sticky2 <= |w_norm[MW-2-FW:0];
            end
        end
    end

    // S3: registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3 <= 1'b0; r_sow3 <= 1'b0; r_eow3 <= 1'b0; r_data3 <= '0;
        end else if (w_adv) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_sow3 <= r_sow2; r_eow3 <= r_eow2; r_data3 <= w_res;
            end
        end
    end

    assign rts_o  = r_v3;
    assign sow_o  = r_sow3;
    assign eow_o  = r_eow3;
    assign data_o = r_data3;

endmodule

// File: tb/tb_quire16_1_to_posit.sv
// Bench for quire16_1_to_posit: directed spec vectors, latency, stall, reset and random
// streams checked against a bit-string reference model and an in-order scoreboard.
module tb_quire16_1_to_posit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rts_i, rtr_o, sow_i, eow_i, rtr_i, rts_o, sow_o, eow_o;
    logic [127:0] data_i;
    logic [15:0]  data_o;

    quire16_1_to_posit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rts_i  (rts_i),
        .rtr_o  (rtr_o),
        .sow_i  (sow_i),
        .eow_i  (eow_i),
        .data_i (data_i),
        .rtr_i  (rtr_i),
        .rts_o  (rts_o),
        .sow_o  (sow_o),
        .eow_o  (eow_o),
        .data_o (data_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] q;
        logic         sow;
        logic         eow;
        logic [15:0]  exp;
    } beat_t;

    beat_t       src_q[$];
    logic [17:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          stall_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, got, exp);
    endtask

    // Reference: write regime, exponent and every mantissa bit as a bit string, then round
    function automatic logic [15:0] ref_posit(input logic [127:0] q);
        logic [127:0] m;
        logic [15:0]  body;
        int           p, scale, k, e;
        bit           s, guard, st;
        bit           bits[$];
        if (q == (128'(1) << 127)) return 16'h8000;
        if (q == 128'd0) return 16'h0000;
        s = q[127];
        m = s ? -q : q;
        p = -1;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        scale = p - 56;
        if (scale >= 28) body = 16'h7FFF;
        else if (scale < -28) body = 16'h0001;
        else begin
            k = (scale >= 0) ? scale / 2 : -((1 - scale) / 2);
            e = scale - 2 * k;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[0]);
            for (int i = p - 1; i >= 0; i--) bits.push_back(m[i]);
            while (bits.size() < 17) bits.push_back(1'b0);
            body = 16'h0;
            for (int i = 0; i < 15; i++) body = {body[14:0], bits[i]};
            guard = bits[15];
            st = 1'b0;
            for (int i = 16; i < bits.size(); i++) st |= bits[i];
            if (guard && (st || body[0])) body = body + 16'd1;
            if (body == 16'h0) body = 16'h0001;
        end
        return s ? -body : body;
    endfunction

    function automatic logic [127:0] rand_quire();
        logic [127:0] r, m;
        int           pos;
        r = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 19) == 0) return 128'd0;
        if ($urandom_range(0, 19) == 0) return 128'(1) << 127;
        pos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(24, 90))
                                          : int'($urandom_range(0, 126));
        m = (pos == 0) ? 128'd0 : (r >> (128 - pos));
        m |= 128'(1) << pos;
        // Sparse tail makes exact ties likely
        if ($urandom_range(0, 1) == 1 && pos > 16) m &= ~((128'(1) << (pos - 16)) - 128'd1);
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    task automatic push_beat(input logic [127:0] q, input logic sow, input logic eow,
                             input logic [15:0] exp);
        beat_t b;
        b.q = q; b.sow = sow; b.eow = eow; b.exp = exp;
        src_q.push_back(b);
    endtask

    // One clock: check outputs, drive next inputs, then track handshakes
    task automatic cycle(input bit want_rts, input bit want_rtr);
        @(negedge clk);
        if (stall_prev) check("stall_rts", 32'(rts_o), 32'd1);
        if (rts_o) begin
            if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
            else check("beat", {14'd0, sow_o, eow_o, data_o}, {14'd0, exp_q[0]});
        end
        rtr_i = want_rtr;
        if (want_rts && src_q.size() > 0) begin
            rts_i = 1'b1; data_i = src_q[0].q; sow_i = src_q[0].sow; eow_i = src_q[0].eow;
        end else begin
            rts_i = 1'b0; data_i = {$urandom, $urandom, $urandom, $urandom};
            sow_i = 1'b0; eow_i = 1'b0;
        end
        #1;
        check("rtr_o", 32'(rtr_o), 32'(!(rts_o && !rtr_i)));
        if (rts_o && rtr_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (rts_i && rtr_o) begin
            exp_q.push_back({src_q[0].sow, src_q[0].eow, src_q[0].exp});
            void'(src_q.pop_front());
        end
        stall_prev = rts_o && !rtr_i;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (src_q.size() > 0 || exp_q.size() > 0); i++) cycle(1'b1, 1'b1);
        check(tag, 32'(src_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic latency_test(input logic [127:0] q, input logic [15:0] e);
        int lat;
        push_beat(q, 1'b1, 1'b1, e);
        cycle(1'b1, 1'b1);
        check("lat_accept", 32'(src_q.size()), 32'd0);
        lat = 0;
        do begin
            cycle(1'b0, 1'b1);
            lat++;
        end while (!rts_o && lat < 8);
        check("latency", 32'(lat), 32'd3);
        drain("lat_drain");
    endtask

    logic [127:0] dir_q [10];
    logic [15:0]  dir_e [10];

    initial begin
        dir_q[0] = 128'(1) << 56;                 dir_e[0] = 16'h4000;
        dir_q[1] = -(128'(1) << 56);              dir_e[1] = 16'hC000;
        dir_q[2] = 128'(3) << 55;                 dir_e[2] = 16'h4800;
        dir_q[3] = 128'd0;                        dir_e[3] = 16'h0000;
        dir_q[4] = 128'(1) << 127;                dir_e[4] = 16'h8000;
        dir_q[5] = 128'(1) << 116;                dir_e[5] = 16'h7FFF;
        dir_q[6] = 128'd1;                        dir_e[6] = 16'h0001;
        dir_q[7] = (128'(1) << 56) | (128'(1) << 43);          dir_e[7] = 16'h4000;
        dir_q[8] = (128'(1) << 56) | (128'(3) << 43);          dir_e[8] = 16'h4002;
        dir_q[9] = (128'(1) << 56) | (128'(1) << 43) | 128'd1; dir_e[9] = 16'h4001;

        rst_n = 1'b0; rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; rtr_i = 1'b1; data_i = '0;
        repeat (3) @(negedge clk);
        check("rst_rts", 32'(rts_o), 32'd0);
        check("rst_sow_eow", {30'd0, sow_o, eow_o}, 32'd0);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_rtr", 32'(rtr_o), 32'd1);
        rst_n = 1'b1;

        latency_test(128'(1) << 56, 16'h4000);

        // Directed vectors back-to-back
        for (int i = 0; i < 10; i++) push_beat(dir_q[i], i == 0, i == 9, dir_e[i]);
        drain("dir_drain");

        // 8-beat window with a 6-cycle downstream stall
        for (int i = 0; i < 8; i++) begin
            logic [127:0] q;
            q = rand_quire();
            push_beat(q, i == 0, i == 7, ref_posit(q));
        end
        repeat (4) cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b0);
        drain("stall_drain");

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            logic [127:0] q;
            q = rand_quire();
            push_beat(q, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, ref_posit(q));
        end
        for (int c = 0; c < 4000 && (src_q.size() > 0 || exp_q.size() > 0); c++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        check("rand_done", 32'(src_q.size() + exp_q.size()), 32'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) push_beat(128'(1) << (60 + i), 1'b0, 1'b0, 16'h0);
        repeat (3) cycle(1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rts", 32'(rts_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'h0);
        exp_q.delete(); src_q.delete();
        rts_i = 1'b0; stall_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 1'b1);
        latency_test(128'(3) << 55, 16'h4800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
